// File: rtl/jtag_uart_arbiter.sv
// Shares one JTAG UART Avalon-MM slave port between a 24-bit TX word stream
// (sent as 3 bytes, MSB first) and a periodic RX poller.
module jtag_uart_arbiter #(
  parameter int TX_DEPTH      = 8,
  parameter int POLL_INTERVAL = 64
) (
  input  logic        clk_10MHz,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic [23:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_byte,
  output logic        busy,
  output logic        av_address,
  output logic        av_read_n,
  output logic        av_write_n,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int PW = $clog2(POLL_INTERVAL);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(TX_DEPTH);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {IDLE, RD_DATA, RD_CTRL, WR_BYTE} state_t;

  state_t       state;
  logic [23:0]  fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  count;
  logic [PW-1:0] poll_cnt;
  logic         poll_wrap;
  logic         rx_req;
  logic         tx_blocked;
  logic         last_grant_tx;
  logic [15:0]  wspace_cache;
  logic [1:0]   byte_idx;
  logic         tx_work;
  logic         push;
  logic         pop;
  logic [23:0]  head_word;
  logic [7:0]   head_bytes [4];
  logic         unused_readdata;

  assign tx_ready  = (count != FULL_COUNT);
  assign tx_work   = (count != '0);
  assign busy      = (state != IDLE) || tx_work;
  assign poll_wrap = (poll_cnt == POLL_LAST);
  assign pop       = (state == WR_BYTE) && !av_waitrequest && (byte_idx == 2'd2);
  // A push into a full FIFO is still taken when the head pops on the same edge.
  assign push      = tx_valid && (tx_ready || pop);
  assign head_word = fifo_mem[rd_ptr];
  assign unused_readdata = ^av_readdata[14:8];

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_lane
    assign head_bytes[gi] = head_word[23 - 8*gi -: 8];
  end
  assign head_bytes[3] = 8'h00;

  always_ff @(posedge clk_10MHz) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_10MHz) begin
    if (reset) begin
      state         <= IDLE;
      av_read_n     <= 1'b1;
      av_write_n    <= 1'b1;
      av_address    <= 1'b0;
      av_writedata  <= '0;
      rx_valid      <= 1'b0;
      rx_byte       <= '0;
      rx_req        <= 1'b0;
      tx_blocked    <= 1'b0;
      last_grant_tx <= 1'b1;
      wspace_cache  <= '0;
      byte_idx      <= '0;
      poll_cnt      <= '0;
    end else begin
      rx_valid <= 1'b0;
      poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      if (poll_wrap) begin
        rx_req     <= 1'b1;
        tx_blocked <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_req && (last_grant_tx || !tx_work)) begin
            state         <= RD_DATA;
            av_read_n     <= 1'b0;
            av_address    <= 1'b0;
            last_grant_tx <= 1'b0;
          end else if (tx_work && !tx_blocked) begin
            last_grant_tx <= 1'b1;
            if (wspace_cache == '0) begin
              state      <= RD_CTRL;
              av_read_n  <= 1'b0;
              av_address <= 1'b1;
            end else begin
              state        <= WR_BYTE;
              av_write_n   <= 1'b0;
              av_address   <= 1'b0;
              av_writedata <= {24'b0, head_bytes[byte_idx]};
            end
          end
        end

        RD_DATA: begin
          if (!av_waitrequest) begin
            state     <= IDLE;
            av_read_n <= 1'b1;
            // Keep draining while the core reports more bytes waiting.
            rx_req    <= poll_wrap || (av_readdata[31:16] != '0);
            if (av_readdata[15]) begin
              rx_byte  <= av_readdata[7:0];
              rx_valid <= 1'b1;
            end
          end
        end

        RD_CTRL: begin
          if (!av_waitrequest) begin
            state        <= IDLE;
            av_read_n    <= 1'b1;
            wspace_cache <= av_readdata[31:16];
            if (av_readdata[31:16] == '0) tx_blocked <= 1'b1;
          end
        end

        WR_BYTE: begin
          if (!av_waitrequest) begin
            state      <= IDLE;
            av_write_n <= 1'b1;
            if (wspace_cache != '0) wspace_cache <= wspace_cache - 16'd1;
            byte_idx   <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
